sc_alu_multicycle: RTL and testbench

- Execution stage directly downstream of the general-register bank.
- Captures the two operands driven onto data bus A and data bus B by the enabled registers.
- Executes single-cycle arithmetic/logic ops, or iterative one-bit-per-cycle shifts.
- Returns the result, a one-cycle write strobe for the destination register's write input, and status flags.

---
 rtl/sc_alu_multicycle_pkg.sv | 34 +++
 rtl/sc_alu_multicycle_comb.sv | 54 +++++
 rtl/sc_alu_multicycle.sv | 135 +++++++++++++
 tb/tb_sc_alu_multicycle.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sc_alu_multicycle_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for the multicycle ALU.
package sc_alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_NOTA    = 4'd5;
    localparam logic [3:0] ALU_PASSA   = 4'd6;
    localparam logic [3:0] ALU_PASSB   = 4'd7;
    localparam logic [3:0] ALU_SLL     = 4'd8;
    localparam logic [3:0] ALU_SRL     = 4'd9;
    localparam logic [3:0] ALU_SRA     = 4'd10;
    localparam logic [3:0] ALU_RSVD_LO = 4'd11;
    localparam logic [3:0] ALU_RSVD_HI = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/sc_alu_multicycle_comb.sv
// Single-cycle ALU datapath: result and {N,Z,C,V} from the latched operands.
module sc_alu_comb
    import sc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic [3:0]               op_i,
    input  logic [DATAWIDTH_BUS-1:0] a_i,
    input  logic [DATAWIDTH_BUS-1:0] b_i,
    output logic [DATAWIDTH_BUS-1:0] result_o,
    output logic [3:0]               flags_o
);

    localparam int W = DATAWIDTH_BUS;

    logic [W:0] sum;
    logic [W:0] diff;
    logic       carry;
    logic       ovf;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum[W-1:0];
                carry    = sum[W];
                ovf      = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            ALU_SUB: begin
                // Bit W of the widened difference is the unsigned borrow.
                result_o = diff[W-1:0];
                carry    = diff[W];
                ovf      = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
            end
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_NOTA:  result_o = ~a_i;
            ALU_PASSA: result_o = a_i;
            ALU_PASSB: result_o = b_i;
            default:   result_o = '0;
        endcase
        flags_o         = '0;
        flags_o[FLAG_N] = result_o[W-1];
        flags_o[FLAG_Z] = (result_o == '0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
    end

endmodule

// File: rtl/sc_alu_multicycle.sv
// Multicycle ALU execution stage: single-cycle ops via sc_alu_comb, shifts one bit per falling edge.
module sc_alu_multicycle
    import sc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_SHAMT         = 5
) (
    input  logic                               SC_ALUMC_CLOCK_50,
    input  logic                               SC_ALUMC_Reset_InLow,
    input  logic                               SC_ALUMC_Start_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] SC_ALUMC_Op_In,
    input  logic [DATAWIDTH_BUS-1:0]           SC_ALUMC_DataBUS_A_In,
    input  logic [DATAWIDTH_BUS-1:0]           SC_ALUMC_DataBUS_B_In,
    output logic [DATAWIDTH_BUS-1:0]           SC_ALUMC_Result_Out,
    output logic                               SC_ALUMC_Write_OutHigh,
    output logic                               SC_ALUMC_Done_OutHigh,
    output logic                               SC_ALUMC_Busy_OutHigh,
    output logic [3:0]                         SC_ALUMC_Flags_Out
);

    localparam int W = DATAWIDTH_BUS;

    state_t                               state_q, state_d;
    logic [DATAWIDTH_ALU_SELECTION-1:0]   op_q, op_d;
    logic [W-1:0]                         a_q, a_d;
    logic [W-1:0]                         b_q, b_d;
    logic [W-1:0]                         work_q, work_d;
    logic [DATAWIDTH_SHAMT-1:0]           cnt_q, cnt_d;
    logic                                 cout_q, cout_d;
    logic [W-1:0]                         result_q, result_d;
    logic [3:0]                           flags_q, flags_d;

    logic [W-1:0]                         alu_result;
    logic [3:0]                           alu_flags;

    sc_alu_comb #(
        .DATAWIDTH_BUS(DATAWIDTH_BUS)
    ) u_comb (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .result_o(alu_result),
        .flags_o (alu_flags)
    );

    always_ff @(negedge SC_ALUMC_CLOCK_50 or negedge SC_ALUMC_Reset_InLow) begin
        if (!SC_ALUMC_Reset_InLow) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (SC_ALUMC_Start_InHigh) begin
                    op_d   = SC_ALUMC_Op_In;
                    a_d    = SC_ALUMC_DataBUS_A_In;
                    b_d    = SC_ALUMC_DataBUS_B_In;
                    work_d = SC_ALUMC_DataBUS_A_In;
                    cnt_d  = SC_ALUMC_DataBUS_B_In[DATAWIDTH_SHAMT-1:0];
                    cout_d = 1'b0;
                    state_d = is_shift_op(SC_ALUMC_Op_In) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                state_d  = ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DATAWIDTH_SHAMT'(1);
                    case (op_q)
                        ALU_SLL: begin
                            cout_d = work_q[W-1];
                            work_d = {work_q[W-2:0], 1'b0};
                        end
                        ALU_SRL: begin
                            cout_d = work_q[0];
                            work_d = {1'b0, work_q[W-1:1]};
                        end
                        default: begin
                            cout_d = work_q[0];
                            work_d = {work_q[W-1], work_q[W-1:1]};
                        end
                    endcase
                end else begin
                    result_d         = work_q;
                    flags_d          = '0;
                    flags_d[FLAG_N]  = work_q[W-1];
                    flags_d[FLAG_Z]  = (work_q == '0);
                    flags_d[FLAG_C]  = cout_q;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign SC_ALUMC_Result_Out    = result_q;
    assign SC_ALUMC_Flags_Out     = flags_q;
    assign SC_ALUMC_Busy_OutHigh  = (state_q != ST_IDLE);
    assign SC_ALUMC_Done_OutHigh  = (state_q == ST_DONE);
    assign SC_ALUMC_Write_OutHigh = (state_q == ST_DONE);

endmodule

// File: tb/tb_sc_alu_multicycle.sv
// Randomized self-checking bench for sc_alu_multicycle against an arithmetic reference model.
module tb_sc_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        write;
    logic        done;
    logic        busy;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    sc_alu_multicycle #(
        .DATAWIDTH_BUS(32),
        .DATAWIDTH_ALU_SELECTION(4),
        .DATAWIDTH_SHAMT(5)
    ) dut (
        .SC_ALUMC_CLOCK_50     (clk),
        .SC_ALUMC_Reset_InLow  (rst_n),
        .SC_ALUMC_Start_InHigh (start),
        .SC_ALUMC_Op_In        (op),
        .SC_ALUMC_DataBUS_A_In (a),
        .SC_ALUMC_DataBUS_B_In (b),
        .SC_ALUMC_Result_Out   (result),
        .SC_ALUMC_Write_OutHigh(write),
        .SC_ALUMC_Done_OutHigh (done),
        .SC_ALUMC_Busy_OutHigh (busy),
        .SC_ALUMC_Flags_Out    (flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference: flags {N,Z,C,V} from plain integer arithmetic; latency in edges after the start edge.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint s;
        int n = int'(y[4:0]);
        logic c = 1'b0;
        logic v = 1'b0;
        lat = 1;
        case (o)
            4'd0: begin
                r = x + y;
                c = (ux + uy) > 64'hFFFF_FFFF;
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = x - y;
                c = ux < uy;
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~x;
            4'd6: r = x;
            4'd7: r = y;
            4'd8: begin
                r = x << n;
                c = (n > 0) ? x[32-n] : 1'b0;
                lat = n + 1;
            end
            4'd9: begin
                r = x >> n;
                c = (n > 0) ? x[n-1] : 1'b0;
                lat = n + 1;
            end
            4'd10: begin
                r = $unsigned($signed(x) >>> n);
                c = (n > 0) ? x[n-1] : 1'b0;
                lat = n + 1;
            end
            default: r = 32'h0;
        endcase
        f = {r[31], (r == 32'h0), c, v};
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit hold, input bit scramble);
        logic [31:0] er;
        logic [3:0]  ef;
        int          lat;
        int          seen;
        logic [31:0] prev_r;
        logic [3:0]  prev_f;
        bit          stable;
        model(o, x, y, er, ef, lat);
        @(posedge clk);
        prev_r = result;
        prev_f = flags;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        check_eq($sformatf("op%0d busy after start", o), 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        if (scramble) begin op = 4'($urandom); a = $urandom; b = $urandom; end
        seen = -1;
        stable = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            @(posedge clk);
            if (done) begin
                seen = e;
                break;
            end
            if (result !== prev_r || flags !== prev_f || !busy || write) stable = 1'b0;
            if (scramble) begin op = 4'($urandom); a = $urandom; b = $urandom; end
        end
        check_eq($sformatf("op%0d latency", o), 32'(seen), 32'(lat));
        check_eq($sformatf("op%0d result", o), result, er);
        check_eq($sformatf("op%0d flags", o), 32'(flags), 32'(ef));
        check_eq($sformatf("op%0d write", o), 32'(write), 32'd1);
        check_eq($sformatf("op%0d outputs held in flight", o), 32'(stable), 32'd1);
        @(negedge clk);
        @(posedge clk);
        check_eq($sformatf("op%0d done single pulse", o), 32'(done), 32'd0);
        check_eq($sformatf("op%0d idle after done", o), 32'(busy), 32'd0);
        start = 1'b0;
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #3;
        check_eq("reset result", result, 32'h0);
        check_eq("reset flags", 32'(flags), 32'h0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset write", 32'(write), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;

        run_op(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(4'd1,  32'd5,         32'd7,         1'b0, 1'b0);
        run_op(4'd1,  32'd9,         32'd9,         1'b0, 1'b0);
        run_op(4'd10, 32'h8000_0001, 32'd4,         1'b0, 1'b0);
        run_op(4'd9,  32'h0000_000F, 32'd1,         1'b0, 1'b0);
        run_op(4'd8,  32'h1234_5678, 32'd0,         1'b0, 1'b0);
        run_op(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
        run_op(4'd10, 32'h80F0_F00F, 32'd8,         1'b1, 1'b1);

        // Abandon a shift by 10 after its third shifting edge.
        @(posedge clk);
        op = 4'd9; a = 32'hFFFF_0000; b = 32'd10; start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midshift reset result", result, 32'h0);
        check_eq("midshift reset flags", 32'(flags), 32'h0);
        check_eq("midshift reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(posedge clk);
            if (done) saw_done = 1;
        end
        check_eq("no done after reset", 32'(saw_done), 32'd0);
        run_op(4'd0, 32'd2, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] rb;
            rb = $urandom;
            if ($urandom_range(0, 1) == 0) rb = {27'h0, rb[4:0]};
            run_op(4'($urandom_range(0, 15)), $urandom, rb, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
